// File: rtl/v_tile_out_router.sv
// Result router: FIFO-buffers adder output vectors, multicasts each to neighbour tiles.
// Optional ack timeout and ack_err enabled by V_TILE_OUT_ACK_TIMEOUT_EN.
module v_tile_out_router #(
   parameter int width       = 16,
   parameter int num_inputs  = 4,
   parameter int num_dests   = 4,
   parameter int fifo_depth  = 4,
   parameter int ack_timeout = 15
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [width-1:0]            in_data [num_inputs],
   input  logic [num_dests-1:0]        in_dest,
   input  logic [num_dests-1:0]        out_rdy,
   output logic [num_dests-1:0]        out_en,
   output logic [width-1:0]            out_data [num_inputs],
   input  logic [num_dests-1:0]        out_ack,
   output logic [$clog2(fifo_depth):0] fifo_count,
   output logic                        busy,
   output logic                        overflow,
   output logic                        ack_err
);

   localparam int VW = width * num_inputs;
   localparam int PW = $clog2(fifo_depth);
   localparam int CW = PW + 1;
   localparam int DW = (num_dests > 1) ? $clog2(num_dests) : 1;

   typedef enum logic [1:0] {IDLE, ARB, ISSUE, WAIT} state_t;

   state_t               state_q, state_d;
   logic [VW-1:0]        mem_q [fifo_depth];
   logic [VW-1:0]        mem_d [fifo_depth];
   logic [num_dests-1:0] mmask_q [fifo_depth];
   logic [num_dests-1:0] mmask_d [fifo_depth];
   logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [VW-1:0]        odata_q, odata_d, in_vec;
   logic [num_dests-1:0] rem_q, rem_d, en_q, en_d, dsel_oh;
   logic [DW-1:0]        dsel;
   logic                 ovf_q, ovf_d;
   logic                 empty, full, pop, push, ack_hit, timeout;

   always_comb begin
      in_vec = '0;
      for (int i = 0; i < num_inputs; i++)
         in_vec[i*width +: width] = in_data[i];
   end

   // Lowest pending destination; rem is frozen between ARB and WAIT exit
   always_comb begin
      dsel = '0;
      for (int i = num_dests - 1; i >= 0; i--)
         if (rem_q[i]) dsel = DW'(i);
   end

   assign dsel_oh = num_dests'(1) << dsel;
   assign ack_hit = out_ack[dsel];
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(fifo_depth));
   assign pop     = (state_q == IDLE) && !empty;
   assign push    = in_valid && (!full || pop);

   always_comb begin
      mem_d   = mem_q;
      mmask_d = mmask_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q | (in_valid & ~push);
      if (push) begin
         mem_d[wr_q]   = in_vec;
         mmask_d[wr_q] = in_dest;
         wr_d          = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      odata_d = odata_q;
      en_d    = '0;
      unique case (state_q)
         IDLE: if (!empty) begin
            odata_d = mem_q[rd_q];
            rem_d   = mmask_q[rd_q];
            state_d = (mmask_q[rd_q] != '0) ? ARB : IDLE;
         end
         ARB: if (out_rdy[dsel]) begin
            en_d    = dsel_oh;
            state_d = ISSUE;
         end
         ISSUE: state_d = WAIT;
         WAIT: if (ack_hit || timeout) begin
            rem_d   = rem_q & ~dsel_oh;
            state_d = ((rem_q & ~dsel_oh) != '0) ? ARB : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef V_TILE_OUT_ACK_TIMEOUT_EN
   localparam int TW = $clog2(ack_timeout + 1);

   logic [TW-1:0] tmr_q, tmr_d;
   logic          err_q, err_d;

   // An ack on the last allowed cycle wins over the timeout
   always_comb begin
      tmr_d   = tmr_q;
      timeout = (state_q == WAIT) && !ack_hit &&
                (tmr_q == TW'(ack_timeout - 1));
      err_d   = err_q | timeout;
      if (state_q == ISSUE)
         tmr_d = '0;
      else if (state_q == WAIT)
         tmr_d = tmr_q + TW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tmr_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmr_q <= tmr_d;
         err_q <= err_d;
      end
   end

   assign ack_err = err_q;
`else
   assign timeout = 1'b0;
   assign ack_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      mem_q   <= mem_d;
      mmask_q <= mmask_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         odata_q <= '0;
         rem_q   <= '0;
         en_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         odata_q <= odata_d;
         rem_q   <= rem_d;
         en_q    <= en_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      for (int i = 0; i < num_inputs; i++)
         out_data[i] = odata_q[i*width +: width];
   end

   assign out_en     = en_q;
   assign fifo_count = cnt_q;
   assign overflow   = ovf_q;
   assign busy       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_v_tile_out_router.sv
// Bench for v_tile_out_router: directed scenarios plus random traffic,
// checked every cycle against a queue-based delivery model.
module tb_v_tile_out_router;

   localparam int W  = 16;
   localparam int NI = 4;
   localparam int ND = 4;
   localparam int FD = 4;
   localparam int TO = 15;
`ifdef V_TILE_OUT_ACK_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [W-1:0]  in_data [NI];
   logic [ND-1:0] in_dest;
   logic [ND-1:0] out_rdy;
   logic [ND-1:0] out_en;
   logic [W-1:0]  out_data [NI];
   logic [ND-1:0] out_ack;
   logic [2:0]    fifo_count;
   logic          busy, overflow, ack_err;

   always #5 clk = ~clk;

   v_tile_out_router dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_dest    (in_dest),
      .out_rdy    (out_rdy),
      .out_en     (out_en),
      .out_data   (out_data),
      .out_ack    (out_ack),
      .fifo_count (fifo_count),
      .busy       (busy),
      .overflow   (overflow),
      .ack_err    (ack_err)
   );

   typedef struct packed {
      logic [63:0] v;
      logic [3:0]  m;
   } ent_t;

   // Model: queued entries plus the entry being delivered
   ent_t        mq [$];
   int          ph;
   logic [63:0] m_data;
   logic [3:0]  m_rem;
   logic [3:0]  m_en;
   int          m_tgt;
   int          m_wait;
   bit          m_ovf, m_err;

   logic [3:0]  en_log [$];
   logic [15:0] lane_log [$];
   int          n_vec = 0;
   int          n_bad = 0;
   int          pend = -1;
   int          pend_cnt = 0;

   function automatic int lowest(input logic [3:0] m);
      for (int i = 0; i < 4; i++)
         if (m[i]) return i;
      return 0;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      ent_t        h;
      logic [63:0] v;
      if (reset) begin
         mq.delete();
         ph     = 0;
         m_data = '0;
         m_rem  = '0;
         m_en   = '0;
         m_wait = 0;
         m_ovf  = 1'b0;
         m_err  = 1'b0;
         return;
      end
      m_en = '0;
      case (ph)
         0: if (mq.size() > 0) begin
            h      = mq.pop_front();
            m_data = h.v;
            m_rem  = h.m;
            ph     = (h.m != 0) ? 1 : 0;
         end
         1: begin
            m_tgt = lowest(m_rem);
            if (out_rdy[m_tgt]) begin
               m_en[m_tgt] = 1'b1;
               ph = 2;
            end
         end
         2: begin
            ph     = 3;
            m_wait = 0;
         end
         default: begin
            m_wait++;
            if (out_ack[m_tgt] || (TO_EN && m_wait == TO)) begin
               if (!out_ack[m_tgt]) m_err = 1'b1;
               m_rem[m_tgt] = 1'b0;
               ph = (m_rem != 0) ? 1 : 0;
            end
         end
      endcase
      if (in_valid) begin
         for (int i = 0; i < NI; i++) v[i*W +: W] = in_data[i];
         h.v = v;
         h.m = in_dest;
         if (mq.size() < FD) mq.push_back(h);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic compare();
      chk("out_en", 64'(out_en), 64'(m_en));
      for (int i = 0; i < NI; i++)
         chk("out_data", 64'(out_data[i]), 64'(m_data[i*W +: W]));
      chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
      chk("busy", 64'(busy), 64'(ph != 0 || mq.size() != 0));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("ack_err", 64'(ack_err), 64'(m_err));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
      if (out_en != 0) begin
         en_log.push_back(out_en);
         lane_log.push_back(out_data[0]);
      end
   endtask

   // Neighbour tiles: ack the strobed port lo..hi cycles later
   task automatic nbr(input int lo, input int hi, input bit noise,
                      input logic [3:0] deaf);
      logic [3:0] a;
      a = '0;
      if (pend >= 0) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            a[pend] = 1'b1;
            pend = -1;
         end
      end
      if (out_en != 0) begin
         if (deaf[lowest(out_en)]) pend = -1;
         else begin
            pend     = lowest(out_en);
            pend_cnt = $urandom_range(hi, lo);
         end
      end
      if (noise) a = a | 4'($urandom & $urandom & $urandom);
      out_ack = a;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      in_dest  = '0;
      out_rdy  = '0;
      out_ack  = '0;
      pend     = -1;
      cyc();
      reset = 1'b0;
      chk("rst_out_en", 64'(out_en), 64'd0);
      chk("rst_out_data", 64'(out_data[3]), 64'd0);
      chk("rst_count", 64'(fifo_count), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_err", 64'(ack_err), 64'd0);
      en_log.delete();
      lane_log.delete();
   endtask

   task automatic push1(input int base, input logic [3:0] m);
      in_valid = 1'b1;
      for (int i = 0; i < NI; i++) in_data[i] = W'(base + 2 * i);
      in_dest = m;
   endtask

   int ovf_cnt [6] = '{1, 1, 2, 3, 4, 4};
   int err_at;
   int rate;
   logic [3:0] deaf;

   initial begin
      for (int i = 0; i < NI; i++) in_data[i] = '0;
      do_reset();

      // Unicast to port 0
      push1(11, 4'b0001);
      out_rdy = 4'hf;
      cyc();
      in_valid = 1'b0;
      chk("uc_count", 64'(fifo_count), 64'd1);
      nbr(1, 1, 1'b0, 4'h0); cyc();
      chk("uc_arb_en", 64'(out_en), 64'd0);
      nbr(1, 1, 1'b0, 4'h0); cyc();
      chk("uc_issue_en", 64'(out_en), 64'b0001);
      nbr(1, 1, 1'b0, 4'h0); cyc();
      chk("uc_lane0", 64'(out_data[0]), 64'd11);
      chk("uc_lane3", 64'(out_data[3]), 64'd17);
      chk("uc_busy_wait", 64'(busy), 64'd1);
      nbr(1, 1, 1'b0, 4'h0); cyc();
      nbr(1, 1, 1'b0, 4'h0); cyc();
      chk("uc_busy_done", 64'(busy), 64'd0);
      chk("uc_strobes", 64'(en_log.size()), 64'd1);

      // Multicast to ports 1 and 3
      do_reset();
      push1(21, 4'b1010);
      out_rdy = 4'hf;
      cyc();
      in_valid = 1'b0;
      for (int i = 0; i < 14; i++) begin
         nbr(1, 1, 1'b0, 4'h0); cyc();
      end
      chk("mc_strobes", 64'(en_log.size()), 64'd2);
      if (en_log.size() == 2) begin
         chk("mc_first", 64'(en_log[0]), 64'b0010);
         chk("mc_second", 64'(en_log[1]), 64'b1000);
         chk("mc_data", 64'(lane_log[1]), 64'd21);
      end

      // Back-pressure on port 0
      do_reset();
      push1(31, 4'b0001);
      out_rdy = 4'b1110;
      cyc();
      in_valid = 1'b0;
      for (int i = 0; i < 11; i++) begin
         nbr(1, 1, 1'b0, 4'h0); cyc();
         chk("bp_hold", 64'(out_en), 64'd0);
      end
      out_rdy = 4'hf;
      nbr(1, 1, 1'b0, 4'h0); cyc();
      chk("bp_release", 64'(out_en), 64'b0001);
      for (int i = 0; i < 4; i++) begin
         nbr(1, 1, 1'b0, 4'h0); cyc();
      end

      // Overflow: six pushes with all ports stalled
      do_reset();
      for (int k = 0; k < 6; k++) begin
         push1(k + 1, 4'b0001);
         cyc();
         chk("ovf_count", 64'(fifo_count), 64'(ovf_cnt[k]));
         chk("ovf_flag", 64'(overflow), 64'(k == 5));
      end
      in_valid = 1'b0;
      out_rdy  = 4'hf;
      for (int i = 0; i < 40; i++) begin
         nbr(1, 1, 1'b0, 4'h0); cyc();
      end
      chk("ovf_delivered", 64'(lane_log.size()), 64'd5);
      for (int i = 0; i < lane_log.size(); i++)
         chk("ovf_order", 64'(lane_log[i]), 64'(i + 1));

`ifdef V_TILE_OUT_ACK_TIMEOUT_EN
      // Port 0 never acks; port 2 still served
      do_reset();
      push1(41, 4'b0101);
      out_rdy = 4'hf;
      cyc();
      in_valid = 1'b0;
      err_at = -1;
      for (int i = 2; i <= 30; i++) begin
         nbr(1, 1, 1'b0, 4'b0001); cyc();
         if (ack_err && err_at < 0) err_at = i;
      end
      chk("to_err_cycle", 64'(err_at), 64'd19);
      chk("to_strobes", 64'(en_log.size()), 64'd2);
      if (en_log.size() == 2)
         chk("to_second", 64'(en_log[1]), 64'b0100);
`endif

      // Reset while waiting with two entries queued
      do_reset();
      out_rdy = 4'hf;
      for (int k = 0; k < 3; k++) begin
         push1(51 + k, 4'b0001);
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      chk("rw_queued", 64'(fifo_count), 64'd2);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rw_count", 64'(fifo_count), 64'd0);
      chk("rw_en", 64'(out_en), 64'd0);
      chk("rw_busy", 64'(busy), 64'd0);
      out_ack = 4'b0001;
      cyc();
      out_ack = '0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("rw_late_ack", 64'({busy, out_en}), 64'd0);
      end

      // Random traffic
      do_reset();
      rate = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) rate = $urandom_range(90, 5);
         reset    = ($urandom_range(399, 0) == 0);
         in_valid = ($urandom_range(99, 0) < rate);
         for (int i = 0; i < NI; i++) in_data[i] = W'($urandom);
         in_dest = ND'($urandom);
         out_rdy = (c % 500 < 60) ? 4'($urandom & $urandom)
                                  : 4'($urandom | $urandom);
         deaf = (TO_EN && $urandom_range(7, 0) == 0) ? 4'hf : 4'h0;
         nbr(1, 5, 1'b1, deaf);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/v_tile_out_router.md
# v_tile_out_router

Downstream stage of the vector tile: captures each result vector the tile's adder publishes (`adder_outputs`, `dest_info`, `adder_ack`) into a small FIFO. It then delivers each entry to one or more neighbour tiles over the standard tile write handshake (`write_en` / `write_rdy` / `write_ack`). `dest_info` is treated as a one-hot/multicast destination mask, and destinations are served in ascending index order. The router decouples the single-cycle `adder_ack` pulse from neighbour back-pressure.

## Interface
- `width`, 16: lane width in bits.
- `num_inputs`, 4: lanes per result vector.
- `num_dests`, 4: neighbour ports. This is also the width of the destination mask.
- `fifo_depth`, 4: result entries buffered (power of two, ≥2).
- `ack_timeout`, 15: cycles to wait for `out_ack` before abandoning a destination.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: result strobe (driven by tile `adder_ack`); one entry per high cycle.
- `in_data`  in  `width` × `num_inputs` (unpacked array): result vector (tile `adder_outputs`).
- `in_dest`  in  `num_dests`: destination mask (tile `dest_info`).
- `out_rdy`  in  `num_dests`: neighbour d can accept a write.
- `out_en`  out  `num_dests`: write strobe to neighbour d.
- `out_data`  out  `width` × `num_inputs`: vector being delivered; shared by all destinations.
- `out_ack`  in  `num_dests`: neighbour d accepted the write.
- `fifo_count`  out  $clog2(`fifo_depth`)+1: occupied entries.
- `busy`  out  1: FSM not in IDLE, or FIFO non-empty.
- `overflow`  out  1: sticky; a strobe was dropped because the FIFO was full.
- `ack_err`  out  1: sticky; a destination timed out.

## Operation
- **Push:** on any cycle with `in_valid`=1, `{in_data, in_dest}` is written at the tail.
  - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and `overflow` is set.
- **Zero mask:** an entry with `in_dest`==0 is popped and discarded without any handshake.
- **FSM states:**
  - IDLE: if the FIFO is non-empty, pop the head into holding registers (`out_data`, remaining mask `rem`) and go to ARB. A zero `rem` returns to IDLE instead.
  - ARB: let d = lowest set bit of `rem`. If `out_rdy[d]`=1, go to ISSUE; otherwise stay in ARB. Lower-index destinations block higher ones; there is no skipping.
  - ISSUE: `out_en[d]`=1 for exactly this one cycle, then go to WAIT and clear the timer.
  - WAIT: on `out_ack[d]`=1, clear `rem[d]`. If the timer reaches `ack_timeout` first, clear `rem[d]` and set `ack_err`. Then go to ARB if `rem`≠0, else IDLE.
- **Ignored acks:** `out_ack` on any index other than the current d, or in any state other than WAIT, is ignored.
- **Output hold:** `out_data` holds stable from the IDLE pop until the next pop. `out_en` is registered and at most one bit is high.
- **Reset values:**
  - `out_en`=0, `out_data`=0, `fifo_count`=0, `busy`=0, `overflow`=0, `ack_err`=0.
  - FSM in IDLE, FIFO pointers at 0.
- **Reset mid-transfer:** a `reset` in any state abandons the in-flight entry and flushes the FIFO. `out_en` is low from the following edge.

## Timing
- `in_valid` high in cycle 0 → `fifo_count` increments in cycle 1.
- With an empty FIFO and idle FSM: pop in cycle 1, ARB in cycle 2, `out_en` in cycle 3 if `out_rdy` is high. Minimum latency is 3 cycles.
- `out_ack` is sampled from the cycle after ISSUE. An ack coincident with ISSUE is ignored.
- Per-destination cost is 3 cycles minimum (ARB, ISSUE, WAIT with ack).
- A timeout clears the destination after exactly `ack_timeout` WAIT cycles with no ack.
- Back-to-back `in_valid` is legal every cycle. The FIFO is full after `fifo_depth` unserviced pushes.
- Wrap-around: pointers wrap modulo `fifo_depth`. Full and empty are distinguished by `fifo_count`.

## Configuration
- Macro `V_TILE_OUT_ACK_TIMEOUT_EN`.
- **Defined:** WAIT timer, timeout and `ack_err` behave as described above.
- **Undefined:** no timer is built. WAIT holds indefinitely until `out_ack[d]`, and `ack_err` is tied to 0.

## Test plan
- **Single unicast:** push {11,13,15,17}, dest=4'b0001, `out_rdy`=1111, ack one cycle after `out_en` → `out_en`=0001 in cycle 3 only; `out_data`={11,13,15,17}; `busy` low 2 cycles after the ack.
- **Multicast:** dest=4'b1010 → `out_en`=0010, then after its ack `out_en`=1000. Exactly two strobes, ascending order, same `out_data`.
- **Back-pressure:** `out_rdy[0]`=0 for 10 cycles → FSM stays in ARB and `out_en` stays 0. Raising `out_rdy[0]` gives `out_en[0]` one cycle later.
- **Overflow:** 6 back-to-back pushes with `out_rdy`=0 → `fifo_count` saturates at 4 after the pop of the first entry and the 5th push (count 4). `overflow`=1 is set by the 6th push; delivered entries keep order 1–5.
- **Timeout (macro defined):** never ack dest 0 → after 15 WAIT cycles `ack_err`=1. Dest 2 of the same mask is still served.
- **Reset mid-WAIT with 2 entries queued:** `reset` high for 1 cycle → `fifo_count`=0, `out_en`=0, `busy`=0. A late `out_ack` afterwards has no effect.
